// File: rtl/board_bringup_sequencer.sv
// Board bring-up sequencer: gates kernel/memory reset release on PCIe, PLL lock and DDR3 calibration.
// Optional heartbeat on leds[6] when BRINGUP_HEARTBEAT_EN is defined.
module board_bringup_sequencer #(
  parameter logic [1:0]  MEM_MASK           = 2'b11,
  parameter int unsigned MEM_RESET_CYCLES   = 16,
  parameter int unsigned CAL_TIMEOUT_CYCLES = 1000000,
  parameter int unsigned SETTLE_CYCLES      = 256,
  parameter int unsigned MAX_RETRIES        = 3
) (
  input  logic       config_clk,
  input  logic       resetn,
  input  logic       pcie_npor,
  input  logic       pll_locked,
  input  logic [1:0] mem_cal_success,
  input  logic [1:0] mem_cal_fail,
  output logic       mem_resetn,
  output logic       kernel_resetn,
  output logic       sys_ready,
  output logic       cal_error,
  output logic [1:0] retry_count,
  output logic [7:0] leds
);

  localparam int unsigned MAX_AB  = (MEM_RESET_CYCLES > CAL_TIMEOUT_CYCLES) ? MEM_RESET_CYCLES
                                                                             : CAL_TIMEOUT_CYCLES;
  localparam int unsigned MAX_CYC = (MAX_AB > SETTLE_CYCLES) ? MAX_AB : SETTLE_CYCLES;
  localparam int unsigned CNT_W   = $clog2(MAX_CYC + 1);

  localparam logic [CNT_W-1:0] MRST_LOAD   = CNT_W'(MEM_RESET_CYCLES - 1);
  localparam logic [CNT_W-1:0] CAL_LAST    = CNT_W'(CAL_TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [1:0]       MAX_R       = 2'(MAX_RETRIES);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    WAIT_PCIE = 3'd1,
    WAIT_PLL  = 3'd2,
    MEM_RST   = 3'd3,
    WAIT_CAL  = 3'd4,
    SETTLE    = 3'd5,
    RUN       = 3'd6,
    FAIL      = 3'd7
  } state_t;

  state_t           state_q, state_nxt;
  logic [CNT_W-1:0] cnt_q, cnt_nxt;
  logic [1:0]       retry_nxt;
  logic [5:0]       sync1_q, sync2_q;
  logic             npor_s, pll_s;
  logic [1:0]       succ_s, fail_s;
  logic             cal_ok, cal_bad, attempt_fail, hb_nxt;

  always_ff @(posedge config_clk or negedge resetn) begin
    if (!resetn) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= {pcie_npor, pll_locked, mem_cal_success, mem_cal_fail};
      sync2_q <= sync1_q;
    end
  end

  assign {npor_s, pll_s, succ_s, fail_s} = sync2_q;
  assign cal_ok  = &(succ_s | ~MEM_MASK);
  assign cal_bad = |(fail_s & MEM_MASK);

  // WAIT_CAL and SETTLE share one retry decision via attempt_fail.
  always_comb begin
    state_nxt    = state_q;
    cnt_nxt      = cnt_q;
    retry_nxt    = retry_count;
    attempt_fail = 1'b0;
    if (state_q != IDLE && state_q != FAIL && (!npor_s || !pll_s)) begin
      state_nxt = WAIT_PCIE;
      cnt_nxt   = '0;
      retry_nxt = '0;
    end else begin
      case (state_q)
        IDLE:      state_nxt = WAIT_PCIE;
        WAIT_PCIE: if (npor_s) state_nxt = WAIT_PLL;
        WAIT_PLL: begin
          if (pll_s) begin
            state_nxt = MEM_RST;
            cnt_nxt   = MRST_LOAD;
          end
        end
        MEM_RST: begin
          if (cnt_q == '0) begin
            state_nxt = WAIT_CAL;
            cnt_nxt   = '0;
          end else begin
            cnt_nxt = cnt_q - 1'b1;
          end
        end
        WAIT_CAL: begin
          if (cal_bad || cnt_q == CAL_LAST) begin
            attempt_fail = 1'b1;
          end else if (cal_ok) begin
            state_nxt = SETTLE;
            cnt_nxt   = SETTLE_LOAD;
          end else begin
            cnt_nxt = cnt_q + 1'b1;
          end
        end
        SETTLE: begin
          if (!cal_ok)              attempt_fail = 1'b1;
          else if (cnt_q == '0)     state_nxt = RUN;
          else                      cnt_nxt = cnt_q - 1'b1;
        end
        RUN, FAIL: ;
      endcase
      if (attempt_fail) begin
        if (retry_count < MAX_R) begin
          retry_nxt = retry_count + 1'b1;
          state_nxt = MEM_RST;
          cnt_nxt   = MRST_LOAD;
        end else begin
          state_nxt = FAIL;
        end
      end
    end
  end

`ifdef BRINGUP_HEARTBEAT_EN
  logic [24:0] hb_cnt_q;

  always_ff @(posedge config_clk or negedge resetn) begin
    if (!resetn) hb_cnt_q <= '0;
    else         hb_cnt_q <= hb_cnt_q + 1'b1;
  end

  assign hb_nxt = (state_nxt == RUN) && hb_cnt_q[24];
`else
  assign hb_nxt = 1'b0;
`endif

  // Outputs are decoded from the next state so they change on the same edge as the state register.
  always_ff @(posedge config_clk or negedge resetn) begin
    if (!resetn) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      retry_count   <= '0;
      mem_resetn    <= 1'b0;
      kernel_resetn <= 1'b0;
      sys_ready     <= 1'b0;
      cal_error     <= 1'b0;
      leds          <= '0;
    end else begin
      state_q       <= state_nxt;
      cnt_q         <= cnt_nxt;
      retry_count   <= retry_nxt;
      mem_resetn    <= (state_nxt == WAIT_CAL) || (state_nxt == SETTLE) || (state_nxt == RUN);
      kernel_resetn <= (state_nxt == RUN);
      sys_ready     <= (state_nxt == RUN);
      cal_error     <= (state_nxt == FAIL);
      leds          <= {(state_nxt == RUN), hb_nxt, retry_nxt, (state_nxt == FAIL), state_nxt};
    end
  end

endmodule
